// File: rtl/board_scan_ctrl.sv
// board_scan_ctrl: sequencer for the 64-square move-generation array.
//   CLR clears the square registers, LOAD streams piece codes from the board
//   RAM (1-cycle read latency), SETTLE waits for ray/knight propagation and
//   then snapshots the hit flags, SCAN emits hit square indices over
//   valid/ready, and DONE pulses once.
// Build option:
//   SCAN_SKIP_EN  defined   -> SCAN jumps straight to the next set snapshot bit
//                 undefined -> SCAN visits every index, one cycle per index
module board_scan_ctrl #(
   parameter int unsigned NUM_SQ     = 64,
   parameter int unsigned PIECE_W    = 6,
   parameter int unsigned SETTLE_CYC = 8
) (
   input  logic               clk,
   input  logic               clear,
   input  logic               start,
   input  logic               engine_color,
   output logic [5:0]         brd_rd_addr,
   input  logic [PIECE_W-1:0] brd_rd_data,
   output logic               sq_clear,
   output logic [NUM_SQ-1:0]  sq_enable,
   output logic [PIECE_W-1:0] sq_piece,
   output logic               sq_color,
   input  logic [NUM_SQ-1:0]  sq_hit,
   output logic               mv_valid,
   input  logic               mv_ready,
   output logic [5:0]         mv_sq,
   output logic [6:0]         mv_count,
   output logic               busy,
   output logic               done
);

   localparam logic [5:0]    LAST_IDX = 6'(NUM_SQ - 1);
   localparam int unsigned   SET_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);

   typedef enum logic [2:0] {
      IDLE,
      CLR,
      LOAD,
      SETTLE,
      SCAN,
      DONE
   } state_t;

   state_t              state;
   state_t              state_n;

   logic [5:0]          load_idx;
   logic [SET_W-1:0]    settle_cnt;
   logic [5:0]          scan_idx;
   logic [NUM_SQ-1:0]   snap;

   // Scan lookahead: the square to present this cycle and how SCAN advances
   logic                scan_hit;
   logic [5:0]          scan_pos;
   logic                scan_adv;
   logic                scan_last;
   logic                mv_xfer;
`ifdef SCAN_SKIP_EN
   logic [NUM_SQ-1:0]   remain;
`endif

   // Locate the square to present: next set snapshot bit (skip) or the current index
   always_comb begin
      scan_hit = 1'b0;
      scan_pos = scan_idx;
`ifdef SCAN_SKIP_EN
      remain = snap & ({NUM_SQ{1'b1}} << scan_idx);
      for (int unsigned i = 0; i < NUM_SQ; i++) begin
         if (remain[i] && !scan_hit) begin
            scan_hit = 1'b1;
            scan_pos = 6'(i);
         end
      end
      // No remaining bits ends the scan; otherwise the transfer of the top square does
      scan_last = !scan_hit || (mv_ready && (scan_pos == LAST_IDX));
`else
      scan_hit  = snap[scan_idx];
      scan_last = (scan_idx == LAST_IDX) && (!scan_hit || mv_ready);
`endif
      scan_adv = !scan_hit || mv_ready;
      mv_xfer  = (state == SCAN) && scan_hit && mv_ready;
   end

   // State register
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Next-state logic
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (start) state_n = CLR;
         CLR:     state_n = LOAD;
         LOAD:    if (load_idx == LAST_IDX) state_n = SETTLE;
         SETTLE:  if (settle_cnt == SET_LAST) state_n = SCAN;
         SCAN:    if (scan_last) state_n = DONE;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Datapath registers: counters, hit snapshot, latched colour and move count
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         load_idx   <= '0;
         settle_cnt <= '0;
         scan_idx   <= '0;
         snap       <= '0;
         sq_color   <= 1'b0;
         mv_count   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  sq_color <= engine_color;
                  mv_count <= '0;
               end
            end
            CLR: begin
               load_idx <= '0;
            end
            LOAD: begin
               load_idx   <= load_idx + 6'd1;
               settle_cnt <= '0;
            end
            SETTLE: begin
               settle_cnt <= settle_cnt + 1'b1;
               if (settle_cnt == SET_LAST) begin
                  snap     <= sq_hit;
                  scan_idx <= '0;
               end
            end
            SCAN: begin
               if (mv_xfer) mv_count <= mv_count + 7'd1;
               if (scan_adv) scan_idx <= scan_pos + 6'd1;
            end
            default: ;
         endcase
      end
   end

   // Output decode from state and counters
   always_comb begin
      brd_rd_addr = '0;
      sq_clear    = 1'b0;
      sq_enable   = '0;
      sq_piece    = '0;
      mv_valid    = 1'b0;
      mv_sq       = '0;
      busy        = 1'b0;
      done        = 1'b0;
      case (state)
         CLR: begin
            busy     = 1'b1;
            sq_clear = 1'b1;
         end
         LOAD: begin
            busy        = 1'b1;
            sq_enable   = {{(NUM_SQ-1){1'b0}}, 1'b1} << load_idx;
            sq_piece    = brd_rd_data;
            // Address runs one ahead of the square being loaded, parking on the last
            brd_rd_addr = (load_idx == LAST_IDX) ? LAST_IDX : load_idx + 6'd1;
         end
         SETTLE: begin
            busy = 1'b1;
         end
         SCAN: begin
            busy     = 1'b1;
            mv_valid = scan_hit;
            mv_sq    = scan_hit ? scan_pos : '0;
         end
         DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: ;
      endcase
   end

endmodule
